// File: rtl/mem_responder.sv
// Multi-cycle memory target: accepts one read/write at a time, waits LAT cycles,
// then performs the access on an internal array and pulses Ready for one cycle.
module mem_responder #(
    parameter int unsigned W   = 8,
    parameter int unsigned AW  = 4,
    parameter int unsigned LAT = 2
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Req,
    input  logic          WriteEnable,
    input  logic [AW-1:0] Addr,
    input  logic [W-1:0]  WData,
    output logic          Busy,
    output logic          Ready,
    output logic [W-1:0]  RData
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned CW    = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic            accept_c;
    logic            access_c;
    logic            busy_next;
    logic            ready_next;

    logic            lat_we;
    logic [AW-1:0]   lat_addr;
    logic [W-1:0]    lat_wdata;
    logic [W-1:0]    mem [DEPTH];

    // Next-state, counter and strobe decode
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept_c   = 1'b0;
        access_c   = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (Req) begin
                    accept_c   = 1'b1;
                    cnt_next   = CW'(LAT - 1);
                    state_next = S_WAIT;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CW'(1);
                end else begin
                    access_c   = 1'b1;
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        busy_next  = (state_next == S_WAIT);
        ready_next = (state_next == S_DONE);
    end

    // State, request latch and registered status outputs
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            Busy      <= 1'b0;
            Ready     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            Busy  <= busy_next;
            Ready <= ready_next;
            if (accept_c) begin
                lat_we    <= WriteEnable;
                lat_addr  <= Addr;
                lat_wdata <= WData;
            end
        end
    end

    // Array and read-data register; reset clears every word so an abort leaves no trace
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            RData <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
        end else if (access_c) begin
            if (lat_we) begin
                mem[lat_addr] <= lat_wdata;
            end else begin
                RData <= mem[lat_addr];
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: four instances (LAT=2,1,4,3) driven one at a time;
// a monitor pops expected Ready events and checks timing and RData.
module tb_mem_responder;

    localparam int unsigned NDUT = 4;

    typedef struct {
        int          dut;
        int          cyc;
        logic [7:0]  rd;
    } exp_t;

    logic                  clk = 1'b0;
    logic [NDUT-1:0]       rst_n = '0;
    logic [NDUT-1:0]       req = '0;
    logic [NDUT-1:0]       we = '0;
    logic [NDUT-1:0][3:0]  addr = '0;
    logic [NDUT-1:0][7:0]  wdata = '0;
    logic [NDUT-1:0]       busy;
    logic [NDUT-1:0]       ready;
    logic [NDUT-1:0][7:0]  rdata;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    exp_t       sbq[$];
    logic [7:0] held [NDUT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.W(8), .AW(4), .LAT(2)) u_lat2 (
        .Clock(clk), .Reset(rst_n[0]), .Req(req[0]), .WriteEnable(we[0]), .Addr(addr[0]),
        .WData(wdata[0]), .Busy(busy[0]), .Ready(ready[0]), .RData(rdata[0]));
    mem_responder #(.W(8), .AW(4), .LAT(1)) u_lat1 (
        .Clock(clk), .Reset(rst_n[1]), .Req(req[1]), .WriteEnable(we[1]), .Addr(addr[1]),
        .WData(wdata[1]), .Busy(busy[1]), .Ready(ready[1]), .RData(rdata[1]));
    mem_responder #(.W(8), .AW(4), .LAT(4)) u_lat4 (
        .Clock(clk), .Reset(rst_n[2]), .Req(req[2]), .WriteEnable(we[2]), .Addr(addr[2]),
        .WData(wdata[2]), .Busy(busy[2]), .Ready(ready[2]), .RData(rdata[2]));
    mem_responder #(.W(8), .AW(4), .LAT(3)) u_lat3 (
        .Clock(clk), .Reset(rst_n[3]), .Req(req[3]), .WriteEnable(we[3]), .Addr(addr[3]),
        .WData(wdata[3]), .Busy(busy[3]), .Ready(ready[3]), .RData(rdata[3]));

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every Ready pulse must match the oldest expected event
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < NDUT; k++) begin
            if (ready[k]) begin
                if (sbq.size() == 0) begin
                    check($sformatf("spurious_ready_dut%0d", k), 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("ready_dut", k, e.dut);
                    check($sformatf("ready_cycle_dut%0d", k), cyc, e.cyc);
                    check($sformatf("rdata_dut%0d", k), int'(rdata[k]), int'(e.rd));
                end
            end
        end
    end

    // Issue one request from a negedge; returns at the negedge where Ready is high
    task automatic do_req(input int k, input int lat, input logic w, input logic [3:0] a,
                          input logic [7:0] d, input logic [7:0] exp_rd);
        exp_t e;
        int   nb;
        int   n;
        req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
        if (!w) held[k] = exp_rd;
        e.dut = k; e.cyc = cyc + 1 + lat; e.rd = held[k];
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req[k] = 1'b0;
        nb = 0;
        n  = 0;
        while (!ready[k] && n < 64) begin
            if (busy[k]) nb++;
            n++;
            @(negedge clk);
        end
        check($sformatf("ready_seen_dut%0d", k), int'(ready[k]), 1);
        check($sformatf("busy_cycles_dut%0d", k), nb, lat);
        check($sformatf("busy_in_done_dut%0d", k), int'(busy[k]), 0);
    endtask

    task automatic wait_ready(input int k);
        int n;
        n = 0;
        while (!ready[k] && n < 64) begin
            n++;
            @(negedge clk);
        end
        check($sformatf("ready_wait_dut%0d", k), int'(ready[k]), 1);
    endtask

    initial begin
        int t;
        exp_t e;
        for (int k = 0; k < NDUT; k++) held[k] = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = '1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("reset_busy_dut%0d", k), int'(busy[k]), 0);
            check($sformatf("reset_ready_dut%0d", k), int'(ready[k]), 0);
            check($sformatf("reset_rdata_dut%0d", k), int'(rdata[k]), 0);
        end
        @(negedge clk);

        // 1: load something, then reset mid-cycle and confirm immediate clear
        do_req(0, 2, 1'b1, 4'd5, 8'h77, 8'h00);
        do_req(0, 2, 1'b0, 4'd5, 8'h00, 8'h77);
        @(posedge clk); #3;
        rst_n[0] = 1'b0;
        held[0] = 8'h00;
        #1;
        check("async_rst_rdata", int'(rdata[0]), 0);
        check("async_rst_busy", int'(busy[0]), 0);
        check("async_rst_ready", int'(ready[0]), 0);
        @(negedge clk);
        rst_n[0] = 1'b1;
        do_req(0, 2, 1'b0, 4'd5, 8'h00, 8'h00);

        // 2: write/read back-to-back, writes leave RData alone
        do_req(0, 2, 1'b1, 4'd3, 8'hA5, 8'h00);
        do_req(0, 2, 1'b0, 4'd3, 8'h00, 8'hA5);
        do_req(0, 2, 1'b1, 4'd4, 8'h3C, 8'h00);
        check("rdata_hold_after_write", int'(rdata[0]), 8'hA5);
        do_req(0, 2, 1'b0, 4'd4, 8'h00, 8'h3C);

        // 3: latency sweep
        do_req(1, 1, 1'b1, 4'd9, 8'h5E, 8'h00);
        do_req(1, 1, 1'b0, 4'd9, 8'h00, 8'h5E);
        do_req(1, 1, 1'b0, 4'd0, 8'h00, 8'h00);
        do_req(2, 4, 1'b1, 4'd1, 8'hC3, 8'h00);
        do_req(2, 4, 1'b0, 4'd1, 8'h00, 8'hC3);

        // 4: Req held high; data changes while busy are ignored
        req[3] = 1'b1; we[3] = 1'b1; addr[3] = 4'd7; wdata[3] = 8'h11;
        e.dut = 3; e.cyc = cyc + 4; e.rd = 8'h00;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        wdata[3] = 8'h22;
        wait_ready(3);
        req[3] = 1'b0;
        @(negedge clk);
        do_req(3, 3, 1'b0, 4'd7, 8'h00, 8'h11);
        req[3] = 1'b1; we[3] = 1'b1; addr[3] = 4'd7; wdata[3] = 8'h22;
        t = cyc;
        e.dut = 3; e.cyc = t + 4; e.rd = 8'h11;
        sbq.push_back(e);
        e.cyc = t + 8;
        sbq.push_back(e);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 6) wdata[3] = 8'h33;
            if (i == 8) req[3] = 1'b0;
        end
        do_req(3, 3, 1'b0, 4'd7, 8'h00, 8'h22);

        // 5: reset aborts an in-flight write
        req[3] = 1'b1; we[3] = 1'b1; addr[3] = 4'd2; wdata[3] = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        req[3] = 1'b0;
        @(posedge clk); #2;
        rst_n[3] = 1'b0;
        held[3] = 8'h00;
        #1;
        check("abort_busy", int'(busy[3]), 0);
        check("abort_ready", int'(ready[3]), 0);
        check("abort_rdata", int'(rdata[3]), 0);
        repeat (5) @(negedge clk);
        rst_n[3] = 1'b1;
        repeat (2) @(negedge clk);
        do_req(3, 3, 1'b0, 4'd2, 8'h00, 8'h00);

        // 6: full address sweep
        for (int a = 0; a < 16; a++) begin
            do_req(0, 2, 1'b1, 4'(a), 8'(a) ^ 8'h5A, 8'h00);
        end
        for (int a = 0; a < 16; a++) begin
            do_req(0, 2, 1'b0, 4'(a), 8'h00, 8'(a) ^ 8'h5A);
        end

        repeat (10) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
